ram_arbiter: RTL
================

# ram_arbiter

Shares the single-port 13-bit-address, 32-bit-data program/data RAM between N_REQ requesters, typically the CORE memory port and a UART boot-loader/DMA port. Round-robin arbitration with a registered grant, one RAM access per transaction, and a registered completion pulse with read data. Sits between the requesters and the RAM macro, which has a synchronous read: data appears on `ram_data_out` the cycle after the address is presented.

## Interface
- `N_REQ`, 2: number of requesters; must be ≥ 2.
- `ADDR_W`, 13: RAM word-address width.
- `DATA_W`, 32: RAM data width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester access request.
- `we`  in  N_REQ  per-requester write enable: 1 = write, 0 = read.
- `addr`  in  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `wdata`  in  N_REQ*DATA_W  packed write data, same packing as `addr`.
- `gnt`  out  N_REQ  one-hot, one-cycle accept pulse.
- `done`  out  N_REQ  one-hot, one-cycle completion pulse.
- `rdata`  out  DATA_W  read data; valid while `done` is high after a read.
- `ram_addres`  out  ADDR_W  RAM address.
- `RAM_WE`  out  1  RAM write enable.
- `data_to_mem`  out  DATA_W  RAM write data.
- `ram_data_out`  in  DATA_W  RAM read data.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE.
- **IDLE.** If any `req` bit is set at the clock edge:
  - pick a winner by round-robin, starting at `last+1` and wrapping modulo N_REQ;
  - latch the winner's `we`, `addr` and `wdata` into `we_q`, `addr_q`, `wdata_q`;
  - set `owner` to the winner and `last` to the winner;
  - register `gnt[winner]=1`, go to ACCESS.
  - If no `req` bit is set, stay in IDLE.
- **ACCESS.**
  - `gnt` returns to 0.
  - `ram_addres=addr_q`, `data_to_mem=wdata_q`, `RAM_WE=we_q`.
  - Go to CAPTURE.
- **CAPTURE.**
  - `RAM_WE=0`.
  - At the edge: `rdata<=ram_data_out` on a read; `rdata` holds its previous value on a write.
  - `done[owner]<=1`, go to IDLE.
- Decoding of the RAM outputs:
  - `RAM_WE` is combinational: `(state==ACCESS) & we_q`.
  - `ram_addres` and `data_to_mem` are driven directly from `addr_q` and `wdata_q`.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen.
  - Payload may change in the cycle after `gnt`.
  - A `req` that is still high in the `done` cycle is a new request.
- Requests arriving while the FSM is in ACCESS or CAPTURE are not lost. They stay pending as long as `req` is held.
- Fairness: with all requesters active, each waits at most N_REQ−1 transactions.
- No address range checks. Addresses wrap naturally at 2^ADDR_W words.

## Timing
- Request sampled at edge t (FSM in IDLE):
  - `gnt` high in cycle t+1;
  - `RAM_WE`/address driven in t+1;
  - `ram_data_out` valid in t+2;
  - `done`/`rdata` valid in t+3.
- Latency from request to `done` is 3 cycles.
- Maximum throughput is one access per 3 cycles. The FSM is back in IDLE during the `done` cycle, so a request held through `done` gets its next `gnt` in t+4.
- Reset values: state=IDLE, `last`=N_REQ−1 (requester 0 wins the first tie), `owner`=0, `gnt`=0, `done`=0, `rdata`=0, `addr_q`=0, `wdata_q`=0, `we_q`=0. Therefore `ram_addres`=0, `data_to_mem`=0, `RAM_WE`=0.
- Reset asserted mid-transaction aborts it immediately:
  - `RAM_WE` drops asynchronously;
  - no `done` is issued;
  - the requester must re-request after reset.
- Simultaneous requests: exactly one `gnt` bit is ever set; losers see no pulse.

## Structure
- Shared package `uartp_pkg`: `ADDR_W`/`DATA_W` defaults (13/32) and the `arb_state_t` enum (IDLE, ACCESS, CAPTURE). CORE and peripherals import the same package.
- Sub-module `rr_pick`, purely combinational:
  - inputs: `req[N_REQ]`, `last`;
  - outputs: one-hot `win` and `any`.
- The FSM, latches and output registers stay in `ram_arbiter`.

## Test plan
- Single read: RAM[0x005]=0xDEADBEEF; `req[0]` with `addr`=0x005, `we`=0 → `gnt[0]` at t+1, `done[0]` and `rdata`=0xDEADBEEF at t+3, `RAM_WE` never high.
- Write then read-back: requester 1 writes 0x12345678 to 0x1FFF → `RAM_WE`=1 exactly one cycle (t+1) with `ram_addres`=0x1FFF. A following read from requester 0 returns 0x12345678.
- Contention after reset: `req`=2'b11 held continuously → grants alternate 0,1,0,1 with `gnt` pulses 3 cycles apart; never two bits set at once.
- Back-to-back single requester: `req[1]` held high, addresses 0,1,2 → `done[1]` at t+3, t+6, t+9; `ram_addres` follows 0,1,2.
- Reset mid-ACCESS: assert `rst` during the cycle `RAM_WE`=1 → `RAM_WE` falls same cycle, no `done`; after release the first grant of `req`=2'b11 goes to requester 0.
- Late request: `req[1]` rises while requester 0 is in ACCESS → `gnt[1]` in the cycle after `done[0]`.

Source files
------------

// File: rtl/uartp_pkg.sv
// uartp_pkg: definitions shared by the CORE, the peripherals and the RAM
// arbiter.
//   ADDR_W      : default RAM word-address width (13 bits, 8K words)
//   DATA_W      : default RAM data width (32 bits)
//   arb_state_t : state encoding of the RAM arbiter FSM
package uartp_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  [N_REQ]     : pending requests
//   last [LW]        : index of the previous winner; the search starts at last+1
//   win  [N_REQ]     : one-hot winner (all zero when nothing is requested)
//   any              : at least one request is pending
// N_REQ must be at least 2.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int LW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  // Walk the requesters in priority order last+1, last+2, ... last (mod
  // N_REQ), so the previous winner is considered last of all.
  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port program/data RAM between N_REQ
// requesters with round-robin arbitration, one RAM access per transaction.
//   clk, rst             : clock, asynchronous active-high reset
//   req/we [N_REQ]       : per-requester request and write enable
//   addr   [N_REQ*ADDR_W]: packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata  [N_REQ*DATA_W]: packed write data, same packing
//   gnt    [N_REQ]       : one-cycle accept pulse (registered, one-hot)
//   done   [N_REQ]       : one-cycle completion pulse (registered, one-hot)
//   rdata  [DATA_W]      : read data, valid with done after a read
//   ram_addres, RAM_WE, data_to_mem, ram_data_out : RAM macro port
//     (synchronous read: data follows the address by one cycle)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; arbitrate and latch the winner's payload
// ACCESS  | address/data/write-enable presented to the RAM
// CAPTURE | RAM read data valid; capture it and issue done to the owner
module ram_arbiter
  import uartp_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = uartp_pkg::ADDR_W,
  parameter int DATA_W = uartp_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       ram_addres,
  output logic                    RAM_WE,
  output logic [DATA_W-1:0]       data_to_mem,
  input  logic [DATA_W-1:0]       ram_data_out
);

  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state;
  logic [LW-1:0]     last;
  logic [LW-1:0]     owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [N_REQ-1:0]  win;
  logic              any;
  logic [LW-1:0]     win_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick #(
    .N_REQ (N_REQ),
    .LW    (LW)
  ) u_rr_pick (
    .req  (req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  // Payload mux driven by the one-hot winner.
  always_comb begin
    win_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx   = LW'(i);
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= LW'(N_REQ - 1);
      owner   <= '0;
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            owner   <= win_idx;
            last    <= win_idx;
            gnt     <= win;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (!we_q) rdata <= ram_data_out;
          done[owner] <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational so that reset (which forces IDLE) drops the strobe at once.
  assign RAM_WE      = (state == ACCESS) & we_q;
  assign ram_addres  = addr_q;
  assign data_to_mem = wdata_q;

endmodule
